// File: rtl/ksa_pkg.sv
// Shared definitions for the parametrised RC4 key-scheduling engine.
//   ksa_state_t  : FSM states of ksa_param
//   KSA_LOOP_CYC : cycles spent per S-array index in the swap loop
package ksa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        RD_I,
        LT_I,
        RD_J,
        LT_J,
        WR_I,
        WR_J
    } ksa_state_t;

    localparam int KSA_LOOP_CYC = 6;

endpackage

// File: rtl/ksa_param.sv
// Parametrised RC4 key-scheduling engine (KSA).
// Permutes an external S-array RAM (synchronous read, 1-cycle latency) with a
// KEY_LEN-byte key. An optional identity fill (s[i] = i) runs before the swap
// loop, so no separate init pass is needed.
//
// Handshake: the engine is idle when rdy=1. A run is accepted on a rising
// clock edge where en && rdy; key and init are captured on that edge and rdy
// drops in the following cycle. en is ignored while rdy=0. If en is held high,
// the next run is accepted on the first edge where rdy is 1 again.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         start request
//   init       sampled with en: 1 = identity fill before scheduling
//   rdy        1 = idle, can accept en
//   key        key, byte k = key[8*(KEY_LEN-1-k) +: 8] (MSB first)
//   addr       RAM address
//   rddata     RAM read data, valid the cycle after addr is presented
//   wrdata     RAM write data
//   wren       RAM write enable
//   dbg_state  current FSM state, for observation only
module ksa_param
    import ksa_pkg::*;
#(
    parameter int KEY_LEN = 3,
    parameter int STATE_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 init,
    output logic                 rdy,
    input  logic [8*KEY_LEN-1:0] key,
    output logic [STATE_W-1:0]   addr,
    input  logic [STATE_W-1:0]   rddata,
    output logic [STATE_W-1:0]   wrdata,
    output logic                 wren,
    output ksa_state_t           dbg_state
);

    localparam int KIDX_W = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_LEN - 1);

    ksa_state_t           state_q, state_d;
    logic [STATE_W-1:0]   i_q, i_d;
    logic [STATE_W-1:0]   j_q, j_d;
    logic [STATE_W-1:0]   si_q, si_d;
    logic [STATE_W-1:0]   sj_q, sj_d;
    logic [KIDX_W-1:0]    kidx_q, kidx_d;
    logic [8*KEY_LEN-1:0] key_q, key_d;
    logic [STATE_W-1:0]   kb;

    // Key byte selected by kidx, truncated to STATE_W bits. kidx walks the
    // key bytes as a wrapping counter, so a mux replaces any i % KEY_LEN.
    always_comb begin
        kb = '0;
        for (int k = 0; k < KEY_LEN; k++) begin
            if (kidx_q == KIDX_W'(k)) begin
                kb = key_q[8*(KEY_LEN-1-k) +: STATE_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            kidx_q  <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            kidx_q  <= kidx_d;
            key_q   <= key_d;
        end
    end

    // Next-state and datapath updates. N = 2**STATE_W, so i_q == '1 marks the
    // last index and i wraps to 0 by plain overflow.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        si_d    = si_q;
        sj_d    = sj_q;
        kidx_d  = kidx_q;
        key_d   = key_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    key_d   = key;
                    i_d     = '0;
                    j_d     = '0;
                    kidx_d  = '0;
                    state_d = init ? FILL : RD_I;
                end
            end
            FILL: begin
                i_d = i_q + STATE_W'(1);
                if (i_q == '1) begin
                    state_d = RD_I;
                end
            end
            RD_I: state_d = LT_I;
            LT_I: begin
                si_d    = rddata;
                j_d     = j_q + rddata + kb;
                state_d = RD_J;
            end
            RD_J: state_d = LT_J;
            LT_J: begin
                sj_d    = rddata;
                state_d = WR_I;
            end
            WR_I: state_d = WR_J;
            WR_J: begin
                i_d     = i_q + STATE_W'(1);
                kidx_d  = (kidx_q == KIDX_LAST) ? '0 : kidx_q + KIDX_W'(1);
                state_d = (i_q == '1) ? IDLE : RD_I;
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs: decoded from state and registers only, never from en or
    // rddata. When i == j both writes hit the same address with the same
    // value, which needs no special handling.
    always_comb begin
        rdy    = 1'b0;
        wren   = 1'b0;
        addr   = '0;
        wrdata = '0;
        case (state_q)
            IDLE: rdy = 1'b1;
            FILL: begin
                wren   = 1'b1;
                addr   = i_q;
                wrdata = i_q;
            end
            RD_I, LT_I: addr = i_q;
            RD_J, LT_J: addr = j_q;
            WR_I: begin
                wren   = 1'b1;
                addr   = i_q;
                wrdata = sj_q;
            end
            WR_J: begin
                wren   = 1'b1;
                addr   = j_q;
                wrdata = si_q;
            end
            default: rdy = 1'b0;
        endcase
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_ksa_param.sv
// Directed bench for ksa_param: two instances (KEY_LEN=3/STATE_W=8 and
// KEY_LEN=5/STATE_W=4), each attached to a behavioural synchronous RAM.
module tb_ksa_param;
    import ksa_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // ---------------- instance 1: KEY_LEN=3, STATE_W=8 ----------------
    logic        en1 = 1'b0, init1 = 1'b0;
    logic [23:0] key1 = '0;
    logic        rdy1, wren1;
    logic [7:0]  addr1, rddata1, wrdata1;
    ksa_state_t  st1;
    logic [7:0]  mem1 [256];
    logic        preload1 = 1'b0;

    ksa_param #(.KEY_LEN(3), .STATE_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .init(init1), .rdy(rdy1),
        .key(key1), .addr(addr1), .rddata(rddata1), .wrdata(wrdata1),
        .wren(wren1), .dbg_state(st1)
    );

    always @(posedge clk) begin
        if (preload1) begin
            for (int a = 0; a < 256; a++) mem1[a] <= 8'(a);
        end else if (wren1) begin
            mem1[addr1] <= wrdata1;
        end
        rddata1 <= mem1[addr1];
    end

    // ---------------- instance 2: KEY_LEN=5, STATE_W=4 ----------------
    logic        en2 = 1'b0, init2 = 1'b0;
    logic [39:0] key2 = '0;
    logic        rdy2, wren2;
    logic [3:0]  addr2, rddata2, wrdata2;
    ksa_state_t  st2;
    logic [3:0]  mem2 [16];
    logic        preload2 = 1'b0;

    ksa_param #(.KEY_LEN(5), .STATE_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en2), .init(init2), .rdy(rdy2),
        .key(key2), .addr(addr2), .rddata(rddata2), .wrdata(wrdata2),
        .wren(wren2), .dbg_state(st2)
    );

    always @(posedge clk) begin
        if (preload2) begin
            for (int a = 0; a < 16; a++) mem2[a] <= 4'(a);
        end else if (wren2) begin
            mem2[addr2] <= wrdata2;
        end
        rddata2 <= mem2[addr2];
    end

    // ---------------- scoreboard ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];
    int          gold [256];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference RC4 KSA over an n-entry S-array.
    task automatic compute_gold(input int n, input int klen, input logic [63:0] k);
        int jj, t;
        logic [7:0] kb;
        for (int a = 0; a < n; a++) gold[a] = a;
        jj = 0;
        for (int a = 0; a < n; a++) begin
            kb = 8'(k >> (8 * (klen - 1 - (a % klen))));
            jj = (jj + gold[a] + int'(kb)) % n;
            t        = gold[a];
            gold[a]  = gold[jj];
            gold[jj] = t;
        end
    endtask

    task automatic dump_check(input bit d2, input int n, input string tag);
        for (int a = 0; a < n; a++) begin
            if (d2) check(tag, 64'(mem2[a]), 64'(gold[a]));
            else    check(tag, 64'(mem1[a]), 64'(gold[a]));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the first negedge after the accept edge.
    task automatic start_run(input bit d2, input bit ini, input logic [63:0] k);
        if (d2) begin
            en2 = 1'b1; init2 = ini; key2 = k[39:0];
        end else begin
            en1 = 1'b1; init1 = ini; key1 = k[23:0];
        end
        tick();
        en1 = 1'b0;
        en2 = 1'b0;
    endtask

    // busy ends as the number of negedges after accept that saw rdy=0.
    task automatic wait_done(input bit d2, input int start, input int limit,
                             input string tag, output int busy);
        busy = start;
        while (((d2 ? rdy2 : rdy1) !== 1'b1) && busy < limit) begin
            busy++;
            tick();
        end
        check({tag, "_done"}, 64'(d2 ? rdy2 : rdy1), 64'd1);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // ---------------- directed sequence ----------------
    int busy;
    int nwr;

    initial begin
        // 1. asynchronous reset, observed before any clock edge
        #1 rst_n = 1'b0;
        #1;
        check("rst_rdy",  64'(rdy1),  64'd1);
        check("rst_wren", 64'(wren1), 64'd0);
        check("rst_addr", 64'(addr1), 64'd0);
        check("rst_rdy2", 64'(rdy2),  64'd1);
        tick();
        check("rst_state", 64'(st1), 64'(IDLE));
        rst_n = 1'b1;
        tick();
        check("post_rst_rdy",  64'(rdy1),  64'd1);
        check("post_rst_wren", 64'(wren1), 64'd0);
        check("post_rst_addr", 64'(addr1), 64'd0);

        // 2. init=1, key=0: fill trace plus first three swap iterations
        for (int c = 0; c < 256; c++) exp_q.push_back({8'(c), 8'(c)});
        exp_q.push_back({8'd0, 8'd0}); exp_q.push_back({8'd0, 8'd0});
        exp_q.push_back({8'd1, 8'd1}); exp_q.push_back({8'd1, 8'd1});
        exp_q.push_back({8'd2, 8'd3}); exp_q.push_back({8'd3, 8'd2});
        start_run(1'b0, 1'b1, 64'h0);
        check("rdy_fall", 64'(rdy1), 64'd0);
        nwr = 0;
        for (int c = 0; c < 256 + 3 * KSA_LOOP_CYC; c++) begin
            if (wren1 === 1'b1) begin
                nwr++;
                if (exp_q.size() > 0) check("wr_trace", {48'd0, addr1, wrdata1}, 64'(exp_q.pop_front()));
            end
            tick();
        end
        check("wr_count", 64'(nwr), 64'd262);
        check("wr_q_empty", 64'(exp_q.size()), 64'd0);
        wait_done(1'b0, 256 + 3 * KSA_LOOP_CYC, 4000, "t2", busy);
        check("t2_busy", 64'(busy), 64'(256 * KSA_LOOP_CYC + 256));
        check("t2_idle_wren", 64'(wren1), 64'd0);
        check("t2_idle_addr", 64'(addr1), 64'd0);

        // 3. golden dump, init=1 then init=0 on a preloaded identity RAM
        compute_gold(256, 3, 64'h00033C);
        start_run(1'b0, 1'b1, 64'h00033C);
        wait_done(1'b0, 0, 4000, "t3a", busy);
        check("t3a_busy", 64'(busy), 64'd1792);
        dump_check(1'b0, 256, "t3a_dump");
        preload1 = 1'b1;
        tick();
        preload1 = 1'b0;
        start_run(1'b0, 1'b0, 64'h00033C);
        wait_done(1'b0, 0, 4000, "t3b", busy);
        check("t3b_busy", 64'(busy), 64'd1536);
        dump_check(1'b0, 256, "t3b_dump");

        // 4. en pulses and key/init changes while busy are ignored
        compute_gold(256, 3, 64'h5A0713);
        start_run(1'b0, 1'b1, 64'h5A0713);
        busy = 0;
        while (rdy1 !== 1'b1 && busy < 4000) begin
            busy++;
            en1 = (busy == 10 || busy == 400 || busy == 1000);
            if (en1) begin
                key1  = 24'hFFFFFF;
                init1 = 1'b0;
            end
            tick();
        end
        en1 = 1'b0;
        check("t4_done", 64'(rdy1), 64'd1);
        check("t4_busy", 64'(busy), 64'd1792);
        dump_check(1'b0, 256, "t4_dump");
        tick();
        check("t4_stay_idle_a", 64'(rdy1), 64'd1);
        tick();
        check("t4_stay_idle_b", 64'(rdy1), 64'd1);

        // 5. reset in the middle of the swap loop, then a fresh run with en held
        compute_gold(256, 3, 64'h123456);
        start_run(1'b0, 1'b1, 64'h123456);
        for (int c = 1; c < 256 + 500; c++) tick();
        check("t5_running", 64'(rdy1), 64'd0);
        rst_n = 1'b0;
        #1;
        check("t5_rst_wren",  64'(wren1), 64'd0);
        check("t5_rst_rdy",   64'(rdy1),  64'd1);
        check("t5_rst_addr",  64'(addr1), 64'd0);
        check("t5_rst_state", 64'(st1),   64'(IDLE));
        tick();
        rst_n = 1'b1;
        tick();
        en1 = 1'b1; init1 = 1'b1; key1 = 24'h123456;
        tick();
        check("t5_fresh_start", 64'(rdy1), 64'd0);
        wait_done(1'b0, 0, 4000, "t5", busy);
        check("t5_busy", 64'(busy), 64'd1792);
        dump_check(1'b0, 256, "t5_dump");
        tick();
        check("t5_hold_restart_rdy",  64'(rdy1),  64'd0);
        check("t5_hold_restart_wren", 64'(wren1), 64'd1);
        check("t5_hold_restart_addr", 64'(addr1), 64'd0);
        en1 = 1'b0;
        pulse_reset();

        // 6. KEY_LEN=5, STATE_W=4 instance
        compute_gold(16, 5, 64'h0102030405);
        start_run(1'b1, 1'b1, 64'h0102030405);
        wait_done(1'b1, 0, 400, "t6a", busy);
        check("t6a_busy", 64'(busy), 64'd112);
        dump_check(1'b1, 16, "t6a_dump");
        preload2 = 1'b1;
        tick();
        preload2 = 1'b0;
        start_run(1'b1, 1'b0, 64'h0102030405);
        wait_done(1'b1, 0, 400, "t6b", busy);
        check("t6b_busy", 64'(busy), 64'(16 * KSA_LOOP_CYC));
        dump_check(1'b1, 16, "t6b_dump");
        check("t6_idle_wren", 64'(wren2), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
